uart_tx_arbiter: RTL and testbench

//  Shares one UART_TX instance between N_REQ byte producers using round-robin arbitration.

---
 rtl/uart_tx_arbiter_pkg.sv | 20 ++
 rtl/uart_tx_arbiter_rr.sv | 41 ++++
 rtl/uart_tx_arbiter.sv | 96 +++++++++
 tb/tb_uart_tx_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// State encodings, default byte width and a constant log2.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_LOAD = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin pick: search starts one past ptr.
// Rotates a doubled request vector so a plain priority encode suffices.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter  int N  = 4,
    localparam int PW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] index,
    output logic          any
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic           found;
    int             start;
    int             pos;

    always_comb begin
        start = (int'(ptr) >= N - 1) ? 0 : int'(ptr) + 1;
        dbl   = {req, req} >> start;
        rot   = dbl[N-1:0];
        gnt   = '0;
        index = '0;
        found = 1'b0;
        pos   = 0;
        for (int j = 0; j < N; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                pos   = (start + j) % N;
                index = PW'(pos);
                gnt   = N'(1) << pos;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between N_REQ producers,
// with a TX_DONE watchdog that can abort a stuck frame.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = UART_DATA_W,
    parameter int TIMEOUT_CYC = 1048575
) (
    input  logic                    SCLK,
    input  logic                    SCLR,
    input  logic [N_REQ-1:0]        REQ,
    input  logic [N_REQ*DATA_W-1:0] REQ_DATA,
    output logic [N_REQ-1:0]        GNT,
    output logic                    TX_EN,
    output logic [DATA_W-1:0]       TX_DATA,
    input  logic                    TX_DONE,
    output logic                    BUSY,
    output logic                    TIMEOUT_ERR
);

    localparam int PW    = clog2(N_REQ);
    localparam int TW0   = clog2(TIMEOUT_CYC + 1);
    localparam int TW    = (TW0 < 1) ? 1 : TW0;
    localparam int TLIM  = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
    localparam bit TO_EN = (TIMEOUT_CYC != 0);

    arb_state_t       state;
    logic [PW-1:0]    ptr;
    logic [TW-1:0]    timer;
    logic [N_REQ-1:0] arb_gnt;
    logic [PW-1:0]    arb_idx;
    logic             arb_any;
    logic             expired;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req   (REQ),
        .ptr   (ptr),
        .gnt   (arb_gnt),
        .index (arb_idx),
        .any   (arb_any)
    );

    assign expired = TO_EN && (timer == TW'(TLIM));

    // Outputs are set on the edge that enters each state, so they are registered.
    always_ff @(posedge SCLK or posedge SCLR) begin
        if (SCLR) begin
            state       <= ARB_IDLE;
            ptr         <= PW'(N_REQ - 1);
            timer       <= '0;
            GNT         <= '0;
            TX_EN       <= 1'b0;
            TX_DATA     <= '0;
            BUSY        <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            GNT         <= '0;
            TX_EN       <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
            unique case (state)
                ARB_IDLE: begin
                    if (arb_any) begin
                        state   <= ARB_LOAD;
                        TX_DATA <= REQ_DATA[arb_idx*DATA_W +: DATA_W];
                        GNT     <= arb_gnt;
                        TX_EN   <= 1'b1;
                        BUSY    <= 1'b1;
                        ptr     <= arb_idx;
                    end
                end
                ARB_LOAD: begin
                    state <= ARB_WAIT;
                    timer <= '0;
                end
                ARB_WAIT: begin
                    if (TX_DONE) begin
                        state <= ARB_IDLE;
                        BUSY  <= 1'b0;
                    end else if (expired) begin
                        state       <= ARB_IDLE;
                        BUSY        <= 1'b0;
                        TIMEOUT_ERR <= 1'b1;
                    end else if (timer != {TW{1'b1}}) begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic,
// every cycle compared with a frame-level reference model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 16;

    logic           SCLK = 1'b0;
    logic           SCLR;
    logic [N-1:0]   REQ;
    logic [N*W-1:0] REQ_DATA;
    logic [N-1:0]   GNT;
    logic           TX_EN;
    logic [W-1:0]   TX_DATA;
    logic           TX_DONE;
    logic           BUSY;
    logic           TIMEOUT_ERR;

    uart_tx_arbiter #(
        .N_REQ       (N),
        .DATA_W      (W),
        .TIMEOUT_CYC (TO)
    ) dut (
        .SCLK        (SCLK),
        .SCLR        (SCLR),
        .REQ         (REQ),
        .REQ_DATA    (REQ_DATA),
        .GNT         (GNT),
        .TX_EN       (TX_EN),
        .TX_DATA     (TX_DATA),
        .TX_DONE     (TX_DONE),
        .BUSY        (BUSY),
        .TIMEOUT_ERR (TIMEOUT_ERR)
    );

    always #5 SCLK = ~SCLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a frame is active from the grant edge until
    // TX_DONE (two or more edges later) or TO full wait cycles pass.
    bit           m_act;
    int           m_k;
    int           m_ptr;
    logic [W-1:0] m_data;
    logic [N-1:0] m_gnt;
    bit           m_en;
    bit           m_err;

    int cyc = 0;
    int last_en = 0;
    int last_err = 0;
    int err_cnt = 0;
    int gq[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        int c;
        for (int i = 1; i <= N; i++) begin
            c = (p + i) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_act  = 0;
        m_k    = 0;
        m_ptr  = N - 1;
        m_data = '0;
        m_gnt  = '0;
        m_en   = 0;
        m_err  = 0;
    endtask

    task automatic model_edge();
        int w;
        m_gnt = '0;
        m_en  = 0;
        m_err = 0;
        if (!m_act) begin
            if (|REQ) begin
                w      = rr_pick(REQ, m_ptr);
                m_ptr  = w;
                m_data = REQ_DATA[w*W +: W];
                m_gnt  = N'(1) << w;
                m_en   = 1;
                m_act  = 1;
                m_k    = 0;
            end
        end else begin
            m_k++;
            if (m_k >= 2) begin
                if (TX_DONE) begin
                    m_act = 0;
                end else if (m_k == TO + 1) begin
                    m_act = 0;
                    m_err = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("gnt", 32'(GNT), 32'(m_gnt));
        check("tx_en", 32'(TX_EN), 32'(m_en));
        check("tx_data", 32'(TX_DATA), 32'(m_data));
        check("busy", 32'(BUSY), 32'(m_act));
        check("timeout_err", 32'(TIMEOUT_ERR), 32'(m_err));
    endtask

    task automatic step();
        @(posedge SCLK);
        if (SCLR) model_reset();
        else model_edge();
        #1;
        cyc++;
        compare_all();
        for (int i = 0; i < N; i++)
            if (GNT[i]) gq.push_back(i);
        if (TX_EN) last_en = cyc;
        if (TIMEOUT_ERR) begin
            last_err = cyc;
            err_cnt++;
        end
    endtask

    // UART stand-in returns TX_DONE a few cycles into each frame.
    task automatic run_until(input int n, input int raise_at);
        for (int c = 0; c < 200 && gq.size() < n; c++) begin
            if (raise_at > 0 && gq.size() == raise_at) REQ[3] = 1'b1;
            TX_DONE = m_act && (m_k == 3);
            step();
        end
        TX_DONE = 1'b0;
        check("grant_budget", 32'(gq.size()), 32'(n));
    endtask

    task automatic do_reset();
        SCLR = 1'b1;
        model_reset();
        step();
        step();
        SCLR = 1'b0;
    endtask

    initial begin
        int pct;
        int exp2[5];
        int exp3[6];
        int e0;
        exp2 = '{0, 1, 2, 3, 0};
        exp3 = '{0, 2, 0, 2, 3, 0};
        SCLR     = 1'b1;
        REQ      = '0;
        REQ_DATA = '0;
        TX_DONE  = 1'b0;
        model_reset();
        #1;
        check("async_reset_busy", 32'(BUSY), 32'd0);
        do_reset();

        // Single requester, then release and watch BUSY drop.
        REQ      = 4'b0001;
        REQ_DATA = 32'h000000A5;
        step();
        check("t1_gnt", 32'(GNT), 32'h1);
        REQ = '0;
        for (int i = 0; i < 4; i++) step();
        check("t1_hold", 32'(TX_DATA), 32'hA5);
        TX_DONE = 1'b1;
        step();
        TX_DONE = 1'b0;
        step();
        check("t1_idle", 32'(BUSY), 32'd0);

        // All four requesting: strict rotation.
        do_reset();
        gq.delete();
        REQ      = 4'b1111;
        REQ_DATA = 32'h43322110;
        run_until(5, 0);
        for (int i = 0; i < 5 && i < gq.size(); i++)
            check("t2_order", 32'(gq[i]), 32'(exp2[i]));
        REQ = '0;
        for (int i = 0; i < 6; i++) step();

        // Two requesters alternate; a third joins mid-sequence.
        do_reset();
        gq.delete();
        REQ = 4'b0101;
        run_until(6, 3);
        for (int i = 0; i < 6 && i < gq.size(); i++)
            check("t3_order", 32'(gq[i]), 32'(exp3[i]));
        REQ = '0;
        for (int i = 0; i < 6; i++) step();

        // No TX_DONE: watchdog aborts after TO wait cycles.
        e0       = err_cnt;
        REQ      = 4'b0010;
        REQ_DATA = 32'h0000_7700;
        step();
        REQ = '0;
        for (int i = 0; i < TO + 4; i++) step();
        check("t4_err_count", 32'(err_cnt - e0), 32'd1);
        check("t4_err_gap", 32'(last_err - last_en), 32'(TO + 1));
        gq.delete();
        REQ = 4'b0100;
        run_until(1, 0);
        REQ = '0;
        for (int i = 0; i < 6; i++) step();

        // TX_DONE on the expiry edge wins; stray TX_DONE in idle.
        e0  = err_cnt;
        REQ = 4'b0001;
        step();
        REQ = '0;
        for (int i = 0; i < TO + 4; i++) begin
            TX_DONE = m_act && (m_k == TO);
            step();
        end
        TX_DONE = 1'b1;
        for (int i = 0; i < 3; i++) step();
        TX_DONE = 1'b0;
        check("t5_no_err", 32'(err_cnt - e0), 32'd0);

        // Asynchronous reset in WAIT, then pointer restart.
        REQ      = 4'b0001;
        REQ_DATA = 32'h0000005A;
        step();
        REQ = '0;
        for (int i = 0; i < 4; i++) step();
        #2;
        SCLR = 1'b1;
        #1;
        check("t6_busy", 32'(BUSY), 32'd0);
        check("t6_data", 32'(TX_DATA), 32'd0);
        check("t6_en", 32'(TX_EN), 32'd0);
        check("t6_gnt", 32'(GNT), 32'd0);
        model_reset();
        step();
        step();
        SCLR = 1'b0;
        gq.delete();
        REQ      = 4'b1000;
        REQ_DATA = 32'hC3000000;
        step();
        check("t6_gnt3", 32'(GNT), 32'h8);
        REQ = '0;
        for (int i = 0; i < 4; i++) step();
        TX_DONE = 1'b1;
        step();
        TX_DONE = 1'b0;

        // Random traffic with varying TX_DONE likelihood.
        pct = 10;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                case ($urandom_range(0, 2))
                    0: pct = 0;
                    1: pct = 10;
                    default: pct = 40;
                endcase
            end
            if ($urandom_range(0, 9) < 3) REQ = N'($urandom_range(0, 15));
            REQ_DATA = $urandom;
            TX_DONE  = ($urandom_range(0, 99) < pct);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
